// File: rtl/field_cursor.sv
// Edit-field cursor: wrap-around field pointer driven by edge-detected buttons, with an
// optional inactivity timeout. Define FIELD_CURSOR_AUTOREPEAT_EN for hold-to-repeat stepping.
module field_cursor #(
  parameter int unsigned NUM_FIELDS     = 9,
  parameter int unsigned PTR_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned REPEAT_DELAY   = 16,
  parameter int unsigned REPEAT_RATE    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  edit_en,
  input  logic                  btn_right,
  input  logic                  btn_left,
  output logic [PTR_W-1:0]      ptr,
  output logic [NUM_FIELDS-1:0] sel,
  output logic                  active,
  output logic                  moved,
  output logic                  timeout
);

  typedef enum logic [1:0] {IDLE, ACTIVE, LOCKOUT} state_t;

  state_t                state_q, state_d;
  logic                  btn_right_q, btn_left_q;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [NUM_FIELDS-1:0] sel_q, sel_d;
  logic                  active_q, active_d;
  logic                  moved_q, moved_d;
  logic                  timeout_q, timeout_d;
  logic                  in_active, edge_r, edge_l, rep_r, rep_l, step_r, step_l, tmo_hit;

  if (NUM_FIELDS < 2 || NUM_FIELDS > 15 || (1 << PTR_W) <= NUM_FIELDS ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("field_cursor: illegal parameter combination");
  end

  // A rising edge only counts as a step while the opposite button is released.
  assign in_active = (state_q == ACTIVE) && edit_en;
  assign edge_r    = btn_right & ~btn_right_q & ~btn_left;
  assign edge_l    = btn_left  & ~btn_left_q  & ~btn_right;
  assign step_r    = edge_r | rep_r;
  assign step_l    = edge_l | rep_l;

  if (TIMEOUT_CYCLES > 0) begin : g_tmo
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_q, idle_d;

    always_comb begin
      idle_d = '0;
      if (in_active && !(step_r || step_l)) idle_d = idle_q + TW'(1);
    end

    always_ff @(posedge clk) begin
      if (reset) idle_q <= '0;
      else       idle_q <= idle_d;
    end

    assign tmo_hit = in_active && !(step_r || step_l) &&
                     (idle_q == TW'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_tmo
    assign tmo_hit = 1'b0;
  end

`ifdef FIELD_CURSOR_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  logic          armed_q, armed_d, dir_q, dir_d, phase_q, phase_d;
  logic [RW-1:0] rcnt_q, rcnt_d, thr;
  logic          held, fire;

  // phase_q selects the first-repeat delay versus the steady repeat period.
  assign held  = dir_q ? (btn_right & ~btn_left) : (btn_left & ~btn_right);
  assign thr   = phase_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
  assign fire  = in_active && armed_q && held && ((rcnt_q + RW'(1)) == thr);
  assign rep_r = fire & dir_q;
  assign rep_l = fire & ~dir_q;

  always_comb begin
    armed_d = 1'b0;
    dir_d   = dir_q;
    phase_d = 1'b0;
    rcnt_d  = '0;
    if (in_active) begin
      if (edge_r || edge_l) begin
        armed_d = 1'b1;
        dir_d   = edge_r;
      end else if (armed_q && held) begin
        armed_d = 1'b1;
        phase_d = phase_q | fire;
        rcnt_d  = fire ? '0 : rcnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q <= 1'b0;
      dir_q   <= 1'b0;
      phase_q <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      armed_q <= armed_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      rcnt_q  <= rcnt_d;
    end
  end
`else
  assign rep_r = 1'b0;
  assign rep_l = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      btn_right_q <= 1'b0;
      btn_left_q  <= 1'b0;
      ptr_q       <= '0;
      sel_q       <= '0;
      active_q    <= 1'b0;
      moved_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_right_q <= btn_right;
      btn_left_q  <= btn_left;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      active_q    <= active_d;
      moved_q     <= moved_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (edit_en) state_d = ACTIVE;
      ACTIVE:  if (!edit_en) state_d = IDLE;
               else if (tmo_hit) state_d = LOCKOUT;
      LOCKOUT: if (!edit_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d     = ptr_q;
    moved_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        ptr_d = '0;
        if (edit_en) begin
          ptr_d   = PTR_W'(1);
          moved_d = 1'b1;
        end
      end
      ACTIVE: begin
        if (!edit_en || tmo_hit) begin
          ptr_d     = '0;
          timeout_d = tmo_hit;
        end else if (step_r) begin
          ptr_d   = (ptr_q == PTR_W'(NUM_FIELDS)) ? PTR_W'(1) : ptr_q + PTR_W'(1);
          moved_d = 1'b1;
        end else if (step_l) begin
          ptr_d   = (ptr_q == PTR_W'(1)) ? PTR_W'(NUM_FIELDS) : ptr_q - PTR_W'(1);
          moved_d = 1'b1;
        end
      end
      default: ptr_d = '0;
    endcase
    active_d = (state_d == ACTIVE);
    sel_d    = '0;
    for (int unsigned i = 0; i < NUM_FIELDS; i++) sel_d[i] = (ptr_d == PTR_W'(i + 1));
  end

  assign ptr     = ptr_q;
  assign sel     = sel_q;
  assign active  = active_q;
  assign moved   = moved_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_field_cursor.sv
// Bench for field_cursor: two instances (no timeout / 20-cycle timeout) share stimulus and
// are compared every cycle against a behavioural model of the cursor rules.
module tb_field_cursor;
  localparam int NF = 9;
  localparam int PW = 4;
  localparam int T1 = 20;
  localparam int RD = 16;
  localparam int RR = 4;

  logic clk = 1'b0;
  logic reset = 1'b1, edit_en = 1'b0, btn_right = 1'b0, btn_left = 1'b0;
  logic [PW-1:0] ptr0, ptr1;
  logic [NF-1:0] sel0, sel1;
  logic act0, act1, mov0, mov1, to0, to1;

  int n_checks = 0;
  int n_pass   = 0;

  // model state, index 0 = no timeout, 1 = timeout T1
  int m_mode[2], m_ptr[2], m_idle[2], m_hdir[2], m_hlen[2], m_mov[2], m_to[2];
  int m_tmo[2] = '{0, T1};
  logic pr = 1'b0, pl = 1'b0;

  field_cursor #(.NUM_FIELDS(NF), .PTR_W(PW), .TIMEOUT_CYCLES(0),
                 .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut0 (
    .clk(clk), .reset(reset), .edit_en(edit_en), .btn_right(btn_right), .btn_left(btn_left),
    .ptr(ptr0), .sel(sel0), .active(act0), .moved(mov0), .timeout(to0));

  field_cursor #(.NUM_FIELDS(NF), .PTR_W(PW), .TIMEOUT_CYCLES(T1),
                 .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut1 (
    .clk(clk), .reset(reset), .edit_en(edit_en), .btn_right(btn_right), .btn_left(btn_left),
    .ptr(ptr1), .sel(sel1), .active(act1), .moved(mov1), .timeout(to1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int exp_sel(input int p);
    return (p == 0) ? 0 : (1 << (p - 1));
  endfunction

  task automatic model_edge();
    logic rr, rl;
    int dir;
    rr = btn_right & ~pr;
    rl = btn_left & ~pl;
    for (int k = 0; k < 2; k++) begin
      m_mov[k] = 0;
      m_to[k]  = 0;
      if (reset) begin
        m_mode[k] = 0; m_ptr[k] = 0; m_idle[k] = 0; m_hdir[k] = 0; m_hlen[k] = 0;
      end else if (m_mode[k] == 0) begin
        if (edit_en) begin
          m_mode[k] = 1; m_ptr[k] = 1; m_mov[k] = 1; m_idle[k] = 0; m_hdir[k] = 0;
        end
      end else if (m_mode[k] == 2) begin
        if (!edit_en) m_mode[k] = 0;
      end else if (!edit_en) begin
        m_mode[k] = 0; m_ptr[k] = 0; m_hdir[k] = 0;
      end else begin
        dir = 0;
        if (rr && !btn_left) dir = 1;
        else if (rl && !btn_right) dir = 2;
        if (dir != 0) begin
          m_hdir[k] = dir; m_hlen[k] = 0;
        end else if ((m_hdir[k] == 1 && btn_right && !btn_left) ||
                     (m_hdir[k] == 2 && btn_left && !btn_right)) begin
          m_hlen[k]++;
`ifdef FIELD_CURSOR_AUTOREPEAT_EN
          if (m_hlen[k] == RD || (m_hlen[k] > RD && (m_hlen[k] - RD) % RR == 0)) dir = m_hdir[k];
`endif
        end else begin
          m_hdir[k] = 0;
        end
        if (dir == 1) m_ptr[k] = m_ptr[k] % NF + 1;
        if (dir == 2) m_ptr[k] = (m_ptr[k] + NF - 2) % NF + 1;
        if (dir != 0) begin
          m_mov[k] = 1; m_idle[k] = 0;
        end else if (m_tmo[k] > 0 && m_idle[k] == m_tmo[k] - 1) begin
          m_mode[k] = 2; m_ptr[k] = 0; m_to[k] = 1; m_hdir[k] = 0;
        end else begin
          m_idle[k]++;
        end
      end
    end
    if (reset) begin
      pr = 1'b0; pl = 1'b0;
    end else begin
      pr = btn_right; pl = btn_left;
    end
  endtask

  task automatic compare_all();
    check("ptr0", 32'(ptr0), m_ptr[0]);
    check("sel0", 32'(sel0), exp_sel(m_ptr[0]));
    check("active0", 32'(act0), (m_mode[0] == 1) ? 1 : 0);
    check("moved0", 32'(mov0), m_mov[0]);
    check("timeout0", 32'(to0), m_to[0]);
    check("ptr1", 32'(ptr1), m_ptr[1]);
    check("sel1", 32'(sel1), exp_sel(m_ptr[1]));
    check("active1", 32'(act1), (m_mode[1] == 1) ? 1 : 0);
    check("moved1", 32'(mov1), m_mov[1]);
    check("timeout1", 32'(to1), m_to[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic pulse(input bit right);
    if (right) btn_right = 1'b1; else btn_left = 1'b1;
    tick();
    btn_right = 1'b0; btn_left = 1'b0;
    tick();
  endtask

  initial begin
    int moves, idx;

    tick(); tick();
    reset = 1'b0;
    tick();

    edit_en = 1'b1;
    tick();
    check("entry_ptr", 32'(ptr0), 1);
    check("entry_sel", 32'(sel0), 32'h1);
    check("entry_moved", 32'(mov0), 1);
    tick();
    check("entry_moved_end", 32'(mov0), 0);

    moves = 0;
    for (int i = 0; i < NF; i++) begin
      btn_right = 1'b1; tick(); moves += int'(mov0);
      btn_right = 1'b0; tick(); moves += int'(mov0);
    end
    check("right_wrap_ptr", 32'(ptr0), 1);
    check("right_moves", moves, NF);
    pulse(1'b0);
    check("left_wrap_ptr", 32'(ptr0), NF);

    for (int i = 0; i < 4; i++) pulse(1'b1);
    check("at_four", 32'(ptr0), 4);
    btn_right = 1'b1; btn_left = 1'b1; tick();
    check("both_ptr", 32'(ptr0), 4);
    check("both_moved", 32'(mov0), 0);
    btn_right = 1'b0; btn_left = 1'b0; tick();
    btn_right = 1'b1; tick(); tick();
    btn_left = 1'b1; tick();
    check("held_other_ptr", 32'(ptr0), 5);
    check("held_other_moved", 32'(mov0), 0);
    btn_right = 1'b0; btn_left = 1'b0; tick();

    edit_en = 1'b0; tick();
    edit_en = 1'b1; tick();
    idx = -1;
    for (int k = 1; k <= 40 && idx < 0; k++) begin
      tick();
      if (to1) idx = k;
    end
    check("tmo_latency", idx, T1);
    check("tmo_ptr", 32'(ptr1), 0);
    check("tmo_active", 32'(act1), 0);
    tick(); tick(); tick();
    check("lockout_ptr", 32'(ptr1), 0);
    edit_en = 1'b0; tick();
    edit_en = 1'b1; tick();
    check("reentry_ptr", 32'(ptr1), 1);

    for (int i = 0; i < 5; i++) pulse(1'b1);
    check("at_six", 32'(ptr0), 6);
    edit_en = 1'b0; btn_right = 1'b1; tick();
    check("exit_ptr", 32'(ptr0), 0);
    check("exit_moved", 32'(mov0), 0);
    btn_right = 1'b0; tick();

    edit_en = 1'b1; tick();
    for (int i = 0; i < 4; i++) pulse(1'b1);
    check("at_five", 32'(ptr0), 5);
    reset = 1'b1; tick();
    check("reset_ptr", 32'(ptr0), 0);
    check("reset_sel", 32'(sel0), 0);
    reset = 1'b0; tick();
    check("post_reset_ptr", 32'(ptr0), 1);

    btn_right = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    btn_right = 1'b0; tick();
`ifdef FIELD_CURSOR_AUTOREPEAT_EN
    check("hold30_ptr", 32'(ptr0), 6);
`else
    check("hold30_ptr", 32'(ptr0), 2);
`endif

    for (int c = 0; c < 800; c++) begin
      int rate;
      rate = (c < 400) ? 4 : 24;
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 39) == 0) edit_en = ~edit_en;
      if ($urandom_range(0, rate - 1) == 0) btn_right = ~btn_right;
      if ($urandom_range(0, rate - 1) == 0) btn_left = ~btn_left;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/field_cursor.md
Name: field_cursor

Overview:
- Parametrised edit-field cursor for the RTC configuration path.
- While edit mode is asserted, it steps a field pointer over NUM_FIELDS editable fields (clock s/m/h, day, month, year, timer s/m/h by default).
- Navigation is bidirectional with wrap-around. Button inputs are edge-detected, and an inactivity timeout exits edit mode.
- It drives the address/field select toward the RTC register bank and display overlay.

Parameters:
- NUM_FIELDS, 9, number of editable fields; pointer values 1..NUM_FIELDS, 0 = no field (range 2..15).
- PTR_W, 4, pointer width; must satisfy 2^PTR_W > NUM_FIELDS.
- TIMEOUT_CYCLES, 0, inactivity cycles before forced exit; 0 disables the timeout.
- REPEAT_DELAY, 16, hold cycles before auto-repeat starts (used only with the optional feature).
- REPEAT_RATE, 4, cycles between auto-repeat steps (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- edit_en  in  1  edit-mode request, level
- btn_right  in  1  next field, level, already debounced
- btn_left  in  1  previous field, level, already debounced
- ptr  out  PTR_W  current field, 0 when not editing
- sel  out  NUM_FIELDS  one-hot field select, sel[i] = (ptr == i+1); all-zero when ptr = 0
- active  out  1  high in ACTIVE state
- moved  out  1  one-cycle pulse on every pointer change inside ACTIVE
- timeout  out  1  one-cycle pulse on timeout exit

Behaviour:
- All outputs registered. Reset values: ptr=0, sel=0, active=0, moved=0, timeout=0, state IDLE, button history regs=0, counters=0.
- Edge detect: rise_r = btn_right & ~btn_right_q, rise_l likewise. The _q regs update every cycle, including in IDLE.
- Step: step_r = rise_r & ~btn_left, step_l = rise_l & ~btn_right. Simultaneous presses, or one button rising while the other is held, produce no step.
- States:
  - IDLE: ptr=0. If edit_en=1, go to ACTIVE with ptr=1, active=1, moved=1 on the same edge. Button edges in that cycle are ignored.
  - ACTIVE, on step_r: ptr = (ptr==NUM_FIELDS) ? 1 : ptr+1.
  - ACTIVE, on step_l: ptr = (ptr==1) ? NUM_FIELDS : ptr-1.
  - ACTIVE: moved=1 on the edge ptr changes. No step leaves ptr unchanged.
  - ACTIVE: edit_en=0 → IDLE, ptr=0, active=0, no moved or timeout pulse. edit_en=0 has priority over steps and timeout.
  - ACTIVE timeout (TIMEOUT_CYCLES>0): the inactivity counter clears on entry and on every step, and increments otherwise. When it reaches TIMEOUT_CYCLES-1 with no step that cycle: go to LOCKOUT, ptr=0, active=0, timeout=1 for one cycle.
  - LOCKOUT: stays until edit_en=0, then IDLE. Re-entry requires edit_en deassert and reassert.
- Latency: a rising edge sampled at clock edge k updates ptr/sel/moved at edge k (visible after k). sel always tracks ptr in the same cycle.
- Counter width: clog2(TIMEOUT_CYCLES+1). No counter logic is generated when TIMEOUT_CYCLES=0.
- Reset mid-ACTIVE: returns to IDLE next edge regardless of edit_en. If edit_en is still high, the block re-enters ACTIVE at ptr=1 the following cycle.

Optional Feature:
- Macro FIELD_CURSOR_AUTOREPEAT_EN.
- Defined: a single button held (other low) in ACTIVE for REPEAT_DELAY cycles after its rising edge generates one step. Further steps follow every REPEAT_RATE cycles while held. Each repeat step pulses moved, wraps like a normal step, and clears the inactivity counter. Release or pressing the other button stops repeat and clears the repeat counter.
- Undefined: held buttons produce exactly one step per rising edge. No repeat counters are synthesised.

Test Plan:
- Reset, edit_en=1 → after 1 cycle ptr=1, sel=9'b000000001, active=1, moved pulse of 1 cycle.
- 9 btn_right pulses from ptr=1 → ptr goes 2,3,…,9,1; moved pulses 9 times; btn_left from ptr=1 → ptr=9.
- btn_right and btn_left rising in the same cycle at ptr=4 → ptr stays 4, no moved. btn_right held, then btn_left rises → no step.
- TIMEOUT_CYCLES=20, no presses after entry → timeout pulses 20 cycles after entry, ptr=0, active=0. Holding edit_en=1 keeps ptr=0; toggling edit_en 0→1 re-enters at ptr=1.
- edit_en dropped at ptr=6 in the same cycle as a btn_right edge → ptr=0, no moved. Reset asserted at ptr=5 → ptr=0, sel=0 next edge.
- With FIELD_CURSOR_AUTOREPEAT_EN (delay 16, rate 4), btn_right held 30 cycles from ptr=1 → steps at hold cycles 0, 16, 20, 24, 28 → ptr=6. Without the macro → ptr=2.
